i2s_tdm_tx: RTL and testbench

Multi-channel serial audio transmitter, parametrised in sample width, slot width, channel count and framing mode. Slave to externally generated `sclk` and `lrclk`/frame-sync. Accepts one whole frame of `NCH` samples per valid/ready transfer from the upstream async FIFO. Handles frame buffering, underrun substitution and frame-length checking, and drives `sdo` in I2S or DSP/TDM framing.

---
 rtl/i2s_tdm_tx_pkg.sv | 29 ++
 rtl/i2s_tdm_tx_sync_edge.sv | 39 +++
 rtl/i2s_tdm_tx.sv | 152 +++++++++++++++
 tb/tb_i2s_tdm_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tdm_tx_pkg.sv
// i2s_tdm_tx_pkg: shared types and width helpers for the I2S/TDM transmitter.
// Revision: 1.0
`default_nettype none

package i2s_tdm_tx_pkg;

  typedef enum logic {
    TDM_MODE_I2S = 1'b0,
    TDM_MODE_DSP = 1'b1
  } tdm_mode_e;

  localparam int UNDERRUN_CNT_W = 16;

  // Pointer must be able to hold NCH*SW itself (the "frame complete" value).
  function automatic int ptr_w(input int nch, input int sw);
    return $clog2(nch * sw + 1);
  endfunction

  function automatic int slot_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int bit_w(input int sw);
    return (sw > 1) ? $clog2(sw) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_tdm_tx_sync_edge.sv
// sync_edge: 2-FF synchroniser with registered rise/fall pulses and a level aligned to them.
// Revision: 1.0
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
      fall <= ~sync & prev;
    end
  end

  // prev carries the same pin sample that produced the current pulse.
  assign level = prev;

endmodule

`default_nettype wire

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: frame-buffered I2S / DSP-TDM serial audio transmitter, slave to external sclk/lrclk.
// Revision: 1.0
`default_nettype none

module i2s_tdm_tx
  import i2s_tdm_tx_pkg::*;
#(
  parameter int        DW   = 24,
  parameter int        SW   = 32,
  parameter int        NCH  = 2,
  parameter tdm_mode_e MODE = TDM_MODE_I2S
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NCH*DW-1:0]         s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      sclk,
  input  logic                      lrclk,
  output logic                      sdo,
  output logic                      underrun,
  output logic                      frame_err,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

  localparam int PW  = ptr_w(NCH, SW);
  localparam int SLW = slot_w(NCH);
  localparam int BW  = bit_w(SW);
  localparam logic [PW-1:0] TOTAL = PW'(NCH * SW);
  localparam logic START = (MODE == TDM_MODE_DSP);

  logic sclk_level, sclk_rise, sclk_fall;
  logic lr_level, lr_rise, lr_fall;
  logic unused_sync;

  sync_edge u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge u_sync_lrclk (
    .clk(clk), .rst(rst), .din(lrclk),
    .level(lr_level), .rise(lr_rise), .fall(lr_fall)
  );

  assign unused_sync = ^{sclk_level, lr_rise, lr_fall};

  logic                  lr_last;
  logic [NCH*DW-1:0]     hold;
  logic                  hold_full;
  logic [DW-1:0]         frame [NCH];
  logic                  first;
  logic                  active;
  logic                  ovf;
  logic [PW-1:0]         ptr;
  logic [SLW-1:0]        slot;
  logic [BW-1:0]         bitc;

  logic                  frame_start;
  logic                  xfer;
  logic                  hold_full_n;
  logic [DW-1:0]         sample;
  logic [DW-1:0]         shifted;
  logic                  cur_bit;

  assign frame_start = sclk_rise && (lr_level != lr_last) && (lr_level == START);
  assign xfer        = s_valid && s_ready;

  always_comb begin
    hold_full_n = hold_full;
    if (xfer)
      hold_full_n = 1'b1;
    else if (frame_start && en && hold_full)
      hold_full_n = 1'b0;
  end

  // Offsets at or beyond DW shift everything out, giving the zero padding for free.
  assign sample  = frame[slot];
  assign shifted = sample << bitc;
  assign cur_bit = shifted[DW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      lr_last      <= START;
      hold         <= '0;
      hold_full    <= 1'b0;
      s_ready      <= 1'b0;
      for (int c = 0; c < NCH; c++) frame[c] <= '0;
      first        <= 1'b1;
      active       <= 1'b0;
      ovf          <= 1'b0;
      ptr          <= '0;
      slot         <= '0;
      bitc         <= '0;
      sdo          <= 1'b0;
      underrun     <= 1'b0;
      frame_err    <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      if (sclk_rise) lr_last <= lr_level;
      if (xfer) hold <= s_data;
      hold_full <= hold_full_n;
      s_ready   <= !hold_full_n;

      if (!en) begin
        active <= 1'b0;
        first  <= 1'b1;
        sdo    <= 1'b0;
        ovf    <= 1'b0;
        ptr    <= '0;
        slot   <= '0;
        bitc   <= '0;
      end else if (frame_start) begin
        if (hold_full) begin
          for (int c = 0; c < NCH; c++) frame[c] <= hold[c*DW +: DW];
        end else begin
          for (int c = 0; c < NCH; c++) frame[c] <= '0;
          underrun <= 1'b1;
          if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
        end
        // ovf marks a long frame, whose pointer is parked at TOTAL.
        if (!first && (ptr != TOTAL || ovf)) frame_err <= 1'b1;
        first  <= 1'b0;
        active <= 1'b1;
        ovf    <= 1'b0;
        ptr    <= '0;
        slot   <= '0;
        bitc   <= '0;
      end else if (sclk_fall && active) begin
        if (ptr < TOTAL) begin
          sdo <= cur_bit;
          ptr <= ptr + 1'b1;
          if (bitc == BW'(SW - 1)) begin
            bitc <= '0;
            slot <= slot + 1'b1;
          end else begin
            bitc <= bitc + 1'b1;
          end
        end else begin
          sdo <= 1'b0;
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx: directed scoreboard bench for an I2S (2x24/32) and a DSP (8x16/16) instance.
// Revision: 1.0
`default_nettype none

module tb_i2s_tdm_tx;
  import i2s_tdm_tx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, sclk, lr_a, lr_b, valid_a, valid_b;
  logic [47:0]  data_a;
  logic [127:0] data_b;
  logic         ready_a, ready_b, sdo_a, sdo_b, ur_a, ur_b, fe_a, fe_b;
  logic [15:0]  ucnt_a, ucnt_b;

  i2s_tdm_tx #(.DW(24), .SW(32), .NCH(2), .MODE(TDM_MODE_I2S)) dut_a (
    .clk(clk), .rst(rst), .en(en), .s_data(data_a), .s_valid(valid_a), .s_ready(ready_a),
    .sclk(sclk), .lrclk(lr_a), .sdo(sdo_a), .underrun(ur_a), .frame_err(fe_a),
    .underrun_cnt(ucnt_a)
  );

  i2s_tdm_tx #(.DW(16), .SW(16), .NCH(8), .MODE(TDM_MODE_DSP)) dut_b (
    .clk(clk), .rst(rst), .en(en), .s_data(data_b), .s_valid(valid_b), .s_ready(ready_b),
    .sclk(sclk), .lrclk(lr_b), .sdo(sdo_b), .underrun(ur_b), .frame_err(fe_b),
    .underrun_cnt(ucnt_b)
  );

  int checks = 0;
  int failures = 0;

  bit   sel;
  int   c_nch, c_sw, c_dw;
  logic c_start;

  logic         exp_q[$];
  logic [127:0] frame_q[$];
  logic         prev_exp, m_lr_last;
  bit           m_active, m_first;
  int           m_cnt, m_ur, m_fe, m_ucnt;
  int           seen_ur = 0;
  int           seen_fe = 0;

  wire        w_sdo   = sel ? sdo_b   : sdo_a;
  wire        w_ready = sel ? ready_b : ready_a;
  wire        w_ur    = sel ? ur_b    : ur_a;
  wire        w_fe    = sel ? fe_b    : fe_a;
  wire [15:0] w_ucnt  = sel ? ucnt_b  : ucnt_a;

  always @(negedge clk) begin
    if (w_ur) seen_ur++;
    if (w_fe) seen_fe++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lr(input logic v);
    if (sel) lr_b = v;
    else     lr_a = v;
  endtask

  task automatic push_bits(input logic [127:0] d);
    for (int s = 0; s < c_nch; s++)
      for (int k = 0; k < c_sw; k++)
        exp_q.push_back((k < c_dw) ? d[s*c_dw + c_dw - 1 - k] : 1'b0);
  endtask

  task automatic model_f();
    logic [127:0] d;
    if (!en) return;
    exp_q.delete();
    if (!m_first && m_cnt != c_nch * c_sw) m_fe++;
    m_first  = 1'b0;
    m_active = 1'b1;
    m_cnt    = 0;
    if (frame_q.size() > 0) begin
      d = frame_q.pop_front();
    end else begin
      d = '0;
      m_ur++;
      if (m_ucnt < 65535) m_ucnt++;
    end
    push_bits(d);
  endtask

  // One sclk period: falling edge (with lrclk update), low half, rising edge, high half.
  task automatic fall_rise(input logic lr_v);
    logic e;
    bit   is_f;
    @(negedge clk);
    sclk = 1'b0;
    set_lr(lr_v);
    if (m_active) m_cnt++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
    repeat (3) @(negedge clk);
    chk("sdo_latency", w_sdo, prev_exp);
    @(negedge clk);
    chk("sdo_bit", w_sdo, e);
    prev_exp = e;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    is_f = (lr_v != m_lr_last) && (lr_v == c_start);
    m_lr_last = lr_v;
    if (is_f) model_f();
    repeat (8) @(negedge clk);
    if (is_f) begin
      chk("ready_after_f", w_ready, frame_q.size() == 0);
      chk("underrun_pulses", seen_ur, m_ur);
      chk("frame_err_pulses", seen_fe, m_fe);
      chk("underrun_cnt", w_ucnt, m_ucnt);
    end
  endtask

  task automatic xfer(input logic [127:0] d);
    int n = 0;
    while (!w_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_ready", w_ready, 1'b1);
    if (sel) begin valid_b = 1'b1; data_b = d; end
    else     begin valid_a = 1'b1; data_a = d[47:0]; end
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    chk("ready_fall", w_ready, 1'b0);
    frame_q.push_back(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_sdo", w_sdo, 1'b0);
    chk("rst_ready", w_ready, 1'b0);
    chk("rst_underrun", w_ur, 1'b0);
    chk("rst_frame_err", w_fe, 1'b0);
    chk("rst_ucnt", w_ucnt, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", w_ready, 1'b1);
    frame_q.delete();
    exp_q.delete();
    m_active  = 1'b0;
    m_first   = 1'b1;
    m_ucnt    = 0;
    prev_exp  = 1'b0;
    m_lr_last = sel ? lr_b : lr_a;
  endtask

  task automatic run_frame(input int len, input int xfer_at, input int rst_at,
                           input int en_off_at, input int en_on_at);
    logic [127:0] d;
    logic         lr_v;
    for (int j = 0; j < len; j++) begin
      if (j == xfer_at) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        xfer(d);
      end
      if (j == rst_at) do_reset();
      if (j == en_off_at) begin
        @(negedge clk);
        en = 1'b0;
        m_active = 1'b0;
        m_first  = 1'b1;
        exp_q.delete();
        prev_exp = 1'b0;
      end
      if (j == en_on_at) begin
        @(negedge clk);
        en = 1'b1;
      end
      lr_v = (c_start == 1'b1) ? (j == 0) : (j >= c_sw);
      fall_rise(lr_v);
      if (j == len - 1 && frame_q.size() > 0) chk("ready_blocked", w_ready, 1'b0);
    end
  endtask

  initial begin
    logic [127:0] d0;
    rst = 1'b1; en = 1'b0; sclk = 1'b1; lr_a = 1'b1; lr_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
    sel = 1'b0; c_nch = 2; c_sw = 32; c_dw = 24; c_start = 1'b0;
    m_ur = 0; m_fe = 0; m_cnt = 0;

    repeat (3) @(negedge clk);
    chk("rst_sdo_a", sdo_a, 1'b0);
    chk("rst_ready_a", ready_a, 1'b0);
    chk("rst_ucnt_a", ucnt_a, 16'h0);
    chk("rst_sdo_b", sdo_b, 1'b0);
    chk("rst_ready_b", ready_b, 1'b0);
    chk("rst_ucnt_b", ucnt_b, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_a_after_rst", ready_a, 1'b1);
    chk("ready_b_after_rst", ready_b, 1'b1);
    m_active = 1'b0; m_first = 1'b1; m_ucnt = 0; prev_exp = 1'b0; m_lr_last = lr_a;

    // I2S: fixed frame, then three starved frames.
    en = 1'b1;
    fall_rise(1'b1);
    fall_rise(1'b1);
    d0 = '0;
    d0[23:0]  = 24'hA5A5A5;
    d0[47:24] = 24'h123456;
    xfer(d0);
    run_frame(64, -1, -1, -1, -1);
    run_frame(64, -1, -1, -1, -1);
    run_frame(64, -1, -1, -1, -1);
    run_frame(64, -1, -1, -1, -1);
    chk("underrun_cnt_3", w_ucnt, 16'd3);

    // Short and long frames.
    run_frame(60, 2, -1, -1, -1);
    run_frame(64, 2, -1, -1, -1);
    run_frame(70, 2, -1, -1, -1);
    run_frame(64, 2, -1, -1, -1);
    chk("frame_err_total_2", seen_fe, 2);

    for (int i = 0; i < 30; i++) run_frame(64, 2, -1, -1, -1);

    // Reset mid-slot discards the held frame; next frame underruns without frame_err.
    run_frame(64, 2, 10, -1, -1);
    run_frame(64, -1, -1, -1, -1);
    run_frame(64, 2, -1, -1, -1);
    run_frame(64, -1, -1, -1, -1);

    // Enable dropped mid-frame; data accepted while disabled goes out after re-enable.
    run_frame(64, 30, -1, 20, 40);
    run_frame(64, 2, -1, -1, -1);
    run_frame(64, -1, -1, -1, -1);

    // DSP/TDM instance: 8 slots of 16 bits with a one-bit sync pulse.
    sel = 1'b1; c_nch = 8; c_sw = 16; c_dw = 16; c_start = 1'b1;
    do_reset();
    fall_rise(1'b0);
    fall_rise(1'b0);
    d0 = '0;
    for (int s = 0; s < 8; s++) d0[s*16 +: 16] = 16'(s + 1);
    xfer(d0);
    run_frame(128, -1, -1, -1, -1);
    run_frame(128, -1, -1, -1, -1);
    chk("dsp_frame_err_none", seen_fe, m_fe);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
